// File: rtl/encoder_volume_ctrl.sv
// Volume/mute control fed by the rotary encoder decoder.
// Accelerated saturating volume steps; short press mutes, long press restores.
module encoder_volume_ctrl #(
    parameter int VOL_W            = 8,
    parameter int VOL_MAX          = 255,
    parameter int VOL_DEFAULT      = 128,
    parameter int STEP_SLOW        = 1,
    parameter int STEP_FAST        = 4,
    parameter int FAST_TICKS       = 2_000_000,
    parameter int LONG_PRESS_TICKS = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_state_change_stb,
    input  logic             clockwise,
    input  logic             click,
    input  logic             switch,
    output logic [VOL_W-1:0] volume,
    output logic             mute,
    output logic             vol_update_stb,
    output logic             long_press
);

    localparam int AW = $clog2(FAST_TICKS + 1);
    localparam int PW = $clog2(LONG_PRESS_TICKS + 1);

    localparam logic [VOL_W:0]   MAX_X    = (VOL_W+1)'(VOL_MAX);
    localparam logic [VOL_W:0]   SLOW_X   = (VOL_W+1)'(STEP_SLOW);
    localparam logic [VOL_W:0]   FAST_X   = (VOL_W+1)'(STEP_FAST);
    localparam logic [VOL_W-1:0] DEF_V    = VOL_W'(VOL_DEFAULT);
    localparam logic [AW-1:0]    ACC_SAT  = AW'(FAST_TICKS);
    localparam logic [PW-1:0]    LP_LAST  = PW'(LONG_PRESS_TICKS - 1);

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_PRESSED,
        SW_LONG
    } sw_state_t;

    sw_state_t      sw_state, sw_nxt;
    logic [PW-1:0]  press_cnt, cnt_nxt;
    logic [AW-1:0]  accel_cnt;
    logic           click_q, switch_q, last_dir;
    logic           toggle, long_evt;

    logic           step, step_ok, fast;
    logic [VOL_W:0] size, vol_x, sum_x;
    logic [VOL_W-1:0] vol_nxt;
    logic           mute_nxt;

    // Switch FSM: next state and press events
    always_comb begin
        sw_nxt   = sw_state;
        cnt_nxt  = press_cnt;
        toggle   = 1'b0;
        long_evt = 1'b0;
        case (sw_state)
            SW_IDLE: begin
                if (switch && !switch_q) begin
                    cnt_nxt = '0;
                    sw_nxt  = SW_PRESSED;
                end
            end
            SW_PRESSED: begin
                if (press_cnt == LP_LAST) begin
                    long_evt = 1'b1;
                    sw_nxt   = SW_LONG;
                end else if (!switch) begin
                    toggle = 1'b1;
                    sw_nxt = SW_IDLE;
                end else begin
                    cnt_nxt = press_cnt + 1'b1;
                end
            end
            SW_LONG: begin
                if (!switch) sw_nxt = SW_IDLE;
            end
            default: sw_nxt = SW_IDLE;
        endcase
    end

    // Step datapath; a long-press restore swallows a coincident step
    always_comb begin
        step     = enc_state_change_stb & click & ~click_q;
        step_ok  = step & ~long_evt;
        fast     = (accel_cnt < ACC_SAT) && (clockwise == last_dir);
        size     = fast ? FAST_X : SLOW_X;
        vol_x    = {1'b0, volume};
        sum_x    = vol_x;
        vol_nxt  = volume;
        mute_nxt = mute;
        if (step_ok) begin
            if (clockwise) begin
                sum_x = vol_x + size;
                if (sum_x > MAX_X) sum_x = MAX_X;
            end else begin
                sum_x = (vol_x < size) ? '0 : vol_x - size;
            end
            vol_nxt = sum_x[VOL_W-1:0];
        end
        if (toggle) mute_nxt = ~mute;
        if (long_evt) begin
            vol_nxt  = DEF_V;
            mute_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_state  <= SW_IDLE;
            press_cnt <= '0;
        end else begin
            sw_state  <= sw_nxt;
            press_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            click_q        <= 1'b0;
            switch_q       <= 1'b0;
            last_dir       <= 1'b0;
            accel_cnt      <= ACC_SAT;
            volume         <= DEF_V;
            mute           <= 1'b0;
            vol_update_stb <= 1'b0;
            long_press     <= 1'b0;
        end else begin
            click_q        <= click;
            switch_q       <= switch;
            volume         <= vol_nxt;
            mute           <= mute_nxt;
            vol_update_stb <= (vol_nxt != volume) || (mute_nxt != mute);
            long_press     <= long_evt;
            if (step_ok) begin
                accel_cnt <= '0;
                last_dir  <= clockwise;
            end else if (accel_cnt < ACC_SAT) begin
                accel_cnt <= accel_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_volume_ctrl.sv
// Directed bench for encoder_volume_ctrl with shortened tick thresholds.
// Fast detents are 20 clks apart, slow ones 300; long press is 500 clks.
module tb_encoder_volume_ctrl;

    localparam int FT = 100;
    localparam int LP = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_stb, clockwise, click, switch;
    logic [7:0] volume;
    logic       mute, vol_update_stb, long_press;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;
    int lp_cnt = 0;
    int s0, l0;

    encoder_volume_ctrl #(
        .VOL_W(8), .VOL_MAX(255), .VOL_DEFAULT(128),
        .STEP_SLOW(1), .STEP_FAST(4),
        .FAST_TICKS(FT), .LONG_PRESS_TICKS(LP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enc_state_change_stb(enc_stb),
        .clockwise(clockwise),
        .click(click),
        .switch(switch),
        .volume(volume),
        .mute(mute),
        .vol_update_stb(vol_update_stb),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vol_update_stb) stb_cnt++;
        if (long_press) lp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic detent(input logic cw, input int gap);
        @(negedge clk);
        enc_stb = 1'b1; click = 1'b1; clockwise = cw;
        @(negedge clk);
        enc_stb = 1'b0;
        @(negedge clk);
        click = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press(input int hold);
        @(negedge clk);
        switch = 1'b1;
        repeat (hold) @(negedge clk);
        switch = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enc_stb = 1'b0; clockwise = 1'b0;
        click = 1'b0; switch = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vol", volume, 128);
        check("rst_mute", mute, 0);
        check("rst_stb", vol_update_stb, 0);
        check("rst_lp", long_press, 0);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_vol", volume, 128);
        check("idle_stb", stb_cnt, 0);

        // slow clockwise detents
        detent(1'b1, 297); check("slow1", volume, 129);
        detent(1'b1, 297); check("slow2", volume, 130);
        detent(1'b1, 297); check("slow3", volume, 131);
        check("slow_stb", stb_cnt, 3);

        // acceleration, then a direction change is slow
        detent(1'b1, 17); check("acc1", volume, 132);
        detent(1'b1, 17); check("acc2", volume, 136);
        detent(1'b1, 17); check("acc3", volume, 140);
        detent(1'b0, 17); check("acc_ccw", volume, 139);

        // top saturation
        for (int i = 0; i < 29; i++) detent(1'b1, 17);
        check("climb", volume, 252);
        repeat (300) @(negedge clk);
        detent(1'b1, 17); check("at253", volume, 253);
        s0 = stb_cnt;
        detent(1'b1, 17); check("sat_a", volume, 255);
        detent(1'b1, 17); check("sat_b", volume, 255);
        check("sat_stb", stb_cnt - s0, 1);

        // bottom saturation, no wrap
        for (int i = 0; i < 64; i++) detent(1'b0, 17);
        check("descend", volume, 2);
        s0 = stb_cnt;
        detent(1'b0, 17); check("zero_a", volume, 0);
        detent(1'b0, 17); check("zero_b", volume, 0);
        check("zero_stb", stb_cnt - s0, 1);

        // short presses toggle mute
        s0 = stb_cnt;
        press(200);
        check("mute_on", mute, 1);
        check("mute_on_stb", stb_cnt - s0, 1);
        press(200);
        check("mute_off", mute, 0);
        check("mute_stb", stb_cnt - s0, 2);
        check("short_lp", lp_cnt, 0);

        // reach 200 muted
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 18; i++) detent(1'b1, 17);
        check("to197", volume, 197);
        repeat (300) @(negedge clk);
        for (int i = 0; i < 3; i++) detent(1'b1, 297);
        check("to200", volume, 200);
        press(200);
        check("pre_mute", mute, 1);

        // long press with a detent on the threshold cycle
        s0 = stb_cnt; l0 = lp_cnt;
        @(negedge clk);
        switch = 1'b1;
        repeat (LP) @(negedge clk);
        enc_stb = 1'b1; click = 1'b1; clockwise = 1'b1;
        @(negedge clk);
        enc_stb = 1'b0;
        check("lp_pulse", long_press, 1);
        check("lp_vol", volume, 128);
        check("lp_mute", mute, 0);
        check("lp_stb", vol_update_stb, 1);
        @(negedge clk);
        click = 1'b0;
        check("lp_once", long_press, 0);
        repeat (48) @(negedge clk);
        switch = 1'b0;
        repeat (5) @(negedge clk);
        check("lp_rel_mute", mute, 0);
        check("lp_rel_vol", volume, 128);
        check("lp_cnt", lp_cnt - l0, 1);
        check("lp_stbs", stb_cnt - s0, 1);

        // reset in the middle of a hold
        detent(1'b1, 297);
        check("pre_rst_vol", volume, 129);
        press(200);
        check("pre_rst_mute", mute, 1);
        @(negedge clk);
        switch = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_vol", volume, 128);
        check("mid_rst_mute", mute, 0);
        check("mid_rst_stb", vol_update_stb, 0);
        s0 = stb_cnt; l0 = lp_cnt;
        @(negedge clk); switch = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (600) @(negedge clk);
        check("post_rst_mute", mute, 0);
        check("post_rst_vol", volume, 128);
        check("post_rst_stb", stb_cnt - s0, 0);
        check("post_rst_lp", lp_cnt - l0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
